// File: rtl/uart_pkg.sv
// +----------------------------------------------------------------------------+
// | Module : uart_pkg                                                          |
// | Brief  : Shared state encoding and default timing constants for UART RX.   |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

package uart_pkg;

    localparam int c_state_w        = 3;
    localparam int c_def_oversample = 16;
    localparam int c_def_baud_div   = 27;

    typedef enum logic [c_state_w-1:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

endpackage

`default_nettype wire

// File: rtl/baud_tick_gen.sv
// +----------------------------------------------------------------------------+
// | Module : baud_tick_gen                                                     |
// | Brief  : Oversample tick, one clk wide every BAUD_DIV clks; restartable.   |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module baud_tick_gen
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = c_def_baud_div
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int                 c_cnt_w = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(BAUD_DIV - 1);

    logic [c_cnt_w-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_cnt <= '0;
        end else if (r_cnt == c_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Suppressed on clear so the bit timing restarts cleanly at start detect.
    assign tick = !clear && (r_cnt == c_last);

endmodule

`default_nettype wire

// File: rtl/uart_rx_ctrl.sv
// +----------------------------------------------------------------------------+
// | Module : uart_rx_ctrl                                                      |
// | Brief  : UART RX controller: start detect, mid-bit sampling, shift pulses, |
// |          sticky frame/parity/complete flags for a downstream shift reg.    |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int WORD_LENGTH = 8,
    parameter int OVERSAMPLE  = c_def_oversample,
    parameter int BAUD_DIV    = c_def_baud_div,
    parameter int PARITY_EN   = 0,
    parameter int PARITY_ODD  = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic SerialDataIn,
    input  logic clear_rx_flag,
    output logic sample_bit,
    output logic shift,
    output logic rx_flag,
    output logic frame_err,
    output logic parity_err,
    output logic busy
);

    localparam int                  c_tick_w   = $clog2(OVERSAMPLE);
    localparam logic [c_tick_w-1:0] c_half     = c_tick_w'(OVERSAMPLE / 2 - 1);
    localparam logic [c_tick_w-1:0] c_full     = c_tick_w'(OVERSAMPLE - 1);
    localparam int                  c_bit_w    = (WORD_LENGTH > 1) ? $clog2(WORD_LENGTH) : 1;
    localparam logic [c_bit_w-1:0]  c_last_bit = c_bit_w'(WORD_LENGTH - 1);

    logic                r_sync1;
    logic                r_sync2;
    logic                r_prev;
    state_t              r_state;
    logic [c_tick_w-1:0] r_tick_cnt;
    logic [c_bit_w-1:0]  r_bit_cnt;
    logic                r_acc;
    logic                r_par_next;
    logic                r_sample_bit;
    logic                r_shift;
    logic                r_rx_flag;
    logic                r_frame_err;
    logic                r_parity_err;

    logic                w_start;
    logic                w_tick;
    logic                w_sample;

    assign w_start  = (r_state == IDLE) && r_prev && !r_sync2;
    // Start bit is sampled half a bit in; every later bit a full bit after the previous one.
    assign w_sample = w_tick && (r_tick_cnt == ((r_state == START) ? c_half : c_full));

    baud_tick_gen #(
        .BAUD_DIV (BAUD_DIV)
    ) u_baud_tick_gen (
        .clk   (clk),
        .reset (reset),
        .clear (w_start),
        .tick  (w_tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1      <= 1'b1;
            r_sync2      <= 1'b1;
            r_prev       <= 1'b1;
            r_state      <= IDLE;
            r_tick_cnt   <= '0;
            r_bit_cnt    <= '0;
            r_acc        <= 1'b0;
            r_par_next   <= 1'b0;
            r_sample_bit <= 1'b1;
            r_shift      <= 1'b0;
            r_rx_flag    <= 1'b0;
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            r_sync1 <= SerialDataIn;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            r_shift <= 1'b0;

            // Flag setting below is later in the block, so a coincident set wins.
            if (clear_rx_flag) begin
                r_rx_flag    <= 1'b0;
                r_frame_err  <= 1'b0;
                r_parity_err <= 1'b0;
            end

            if (r_state == IDLE) begin
                if (w_start) begin
                    r_state    <= START;
                    r_tick_cnt <= '0;
                    r_bit_cnt  <= '0;
                    r_acc      <= (PARITY_ODD != 0);
                    r_par_next <= 1'b0;
                end
            end else if (w_tick) begin
                r_tick_cnt <= w_sample ? '0 : r_tick_cnt + 1'b1;
            end

            if (w_sample) begin
                case (r_state)
                    START: begin
                        r_state <= r_sync2 ? IDLE : DATA;
                    end
                    DATA: begin
                        r_shift      <= 1'b1;
                        r_sample_bit <= r_sync2;
                        r_acc        <= r_acc ^ r_sync2;
                        if (r_bit_cnt == c_last_bit) begin
                            r_state <= (PARITY_EN != 0) ? PARITY : STOP;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                    PARITY: begin
                        r_par_next <= (r_sync2 != r_acc);
                        r_state    <= STOP;
                    end
                    STOP: begin
                        r_rx_flag <= 1'b1;
                        if (!r_sync2) begin
                            r_frame_err <= 1'b1;
                        end
                        if (r_par_next) begin
                            r_parity_err <= 1'b1;
                        end
                        r_state <= IDLE;
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign sample_bit = r_sample_bit;
    assign shift      = r_shift;
    assign rx_flag    = r_rx_flag;
    assign frame_err  = r_frame_err;
    assign parity_err = r_parity_err;
    assign busy       = (r_state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_ctrl.sv
// +----------------------------------------------------------------------------+
// | Module : tb_uart_rx_ctrl                                                   |
// | Brief  : Directed self-checking bench for uart_rx_ctrl with bit/word SB.   |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_uart_rx_ctrl;

    logic clk;
    logic reset;
    logic clear;
    logic line;
    logic line_p;

    logic sample_bit, shift, rx_flag, frame_err, parity_err, busy;
    logic sample_bit_p, shift_p, rx_flag_p, frame_err_p, parity_err_p, busy_p;

    int tests;
    int fails;

    logic bitq[$];
    logic [7:0] wordq[$];
    logic [7:0] sr;
    logic [7:0] sr_p;
    int         cnt;

    uart_rx_ctrl #(
        .WORD_LENGTH (8), .OVERSAMPLE (16), .BAUD_DIV (1), .PARITY_EN (0), .PARITY_ODD (0)
    ) dut (
        .clk (clk), .reset (reset), .SerialDataIn (line), .clear_rx_flag (clear),
        .sample_bit (sample_bit), .shift (shift), .rx_flag (rx_flag),
        .frame_err (frame_err), .parity_err (parity_err), .busy (busy)
    );

    uart_rx_ctrl #(
        .WORD_LENGTH (8), .OVERSAMPLE (16), .BAUD_DIV (1), .PARITY_EN (1), .PARITY_ODD (0)
    ) dut_p (
        .clk (clk), .reset (reset), .SerialDataIn (line_p), .clear_rx_flag (clear),
        .sample_bit (sample_bit_p), .shift (shift_p), .rx_flag (rx_flag_p),
        .frame_err (frame_err_p), .parity_err (parity_err_p), .busy (busy_p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Downstream shift register model plus scoreboard for the plain DUT.
    always @(posedge clk) begin
        logic       eb;
        logic [7:0] ew;
        #1;
        if (reset) begin
            cnt = 0;
            sr  = '0;
        end else if (shift) begin
            eb = (bitq.size() != 0) ? bitq.pop_front() : 1'bx;
            chk("sample_bit", {15'd0, sample_bit}, {15'd0, eb});
            sr = {sample_bit, sr[7:1]};
            cnt++;
            if (cnt == 8) begin
                cnt = 0;
                ew  = (wordq.size() != 0) ? wordq.pop_front() : 8'hxx;
                chk("word", {8'd0, sr}, {8'd0, ew});
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (reset) sr_p = '0;
        else if (shift_p) sr_p = {sample_bit_p, sr_p[7:1]};
    end

    task automatic drive(input bit sel, input logic v);
        if (sel) line_p = v;
        else     line   = v;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    // One frame, 16 clks per bit; optional clear pulse lands on the stop-sample edge.
    task automatic send_frame(input bit sel, input logic [7:0] data, input bit par_en,
                              input logic par_bit, input logic stop, input bit clr_at_stop);
        if (!sel) begin
            for (int i = 0; i < 8; i++) bitq.push_back(data[i]);
            wordq.push_back(data);
        end
        drive(sel, 1'b0);
        repeat (16) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            drive(sel, data[i]);
            repeat (16) @(negedge clk);
        end
        if (par_en) begin
            drive(sel, par_bit);
            repeat (16) @(negedge clk);
        end
        drive(sel, stop);
        repeat (10) @(negedge clk);
        if (clr_at_stop) pulse_clear();
        else             @(negedge clk);
        repeat (5) @(negedge clk);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        line   = 1'b1;
        line_p = 1'b1;
        clear  = 1'b0;
        reset  = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_sample_bit", {15'd0, sample_bit}, 16'd1);
        chk("rst_shift",      {15'd0, shift},      16'd0);
        chk("rst_rx_flag",    {15'd0, rx_flag},    16'd0);
        chk("rst_frame_err",  {15'd0, frame_err},  16'd0);
        chk("rst_parity_err", {15'd0, parity_err}, 16'd0);
        chk("rst_busy",       {15'd0, busy},       16'd0);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // Plain 0xA5 frame
        send_frame(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("a5_rx_flag",    {15'd0, rx_flag},    16'd1);
        chk("a5_frame_err",  {15'd0, frame_err},  16'd0);
        chk("a5_parity_err", {15'd0, parity_err}, 16'd0);
        chk("a5_busy",       {15'd0, busy},       16'd0);
        pulse_clear();
        chk("clr_rx_flag",   {15'd0, rx_flag},    16'd0);

        // Short low glitch must be rejected at the start-bit midpoint
        line = 1'b0;
        repeat (4) @(negedge clk);
        line = 1'b1;
        repeat (17) @(negedge clk);
        chk("glitch_busy",    {15'd0, busy},    16'd0);
        chk("glitch_rx_flag", {15'd0, rx_flag}, 16'd0);

        // Framing error, line then held low
        send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (40) @(negedge clk);
        chk("fe_rx_flag",   {15'd0, rx_flag},   16'd1);
        chk("fe_frame_err", {15'd0, frame_err}, 16'd1);
        chk("fe_held_busy", {15'd0, busy},      16'd0);
        pulse_clear();
        line = 1'b1;
        repeat (20) @(negedge clk);
        chk("fe_clr_rx_flag",   {15'd0, rx_flag},   16'd0);
        chk("fe_clr_frame_err", {15'd0, frame_err}, 16'd0);

        // Back-to-back frames, clear coincident with the second flag set
        send_frame(1'b0, 8'h55, 1'b0, 1'b0, 1'b1, 1'b0);
        send_frame(1'b0, 8'hAA, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("b2b_rx_flag",   {15'd0, rx_flag},   16'd1);
        chk("b2b_frame_err", {15'd0, frame_err}, 16'd0);

        // Reset after the third data bit of a 0x5A frame
        bitq.push_back(1'b0);
        bitq.push_back(1'b1);
        bitq.push_back(1'b0);
        line = 1'b0;
        repeat (16) @(negedge clk);
        line = 1'b0; repeat (16) @(negedge clk);
        line = 1'b1; repeat (16) @(negedge clk);
        line = 1'b0; repeat (16) @(negedge clk);
        reset = 1'b1;
        line  = 1'b1;
        @(negedge clk);
        chk("mid_rst_sample_bit", {15'd0, sample_bit}, 16'd1);
        chk("mid_rst_shift",      {15'd0, shift},      16'd0);
        chk("mid_rst_rx_flag",    {15'd0, rx_flag},    16'd0);
        chk("mid_rst_busy",       {15'd0, busy},       16'd0);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        send_frame(1'b0, 8'h81, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("r81_rx_flag",   {15'd0, rx_flag},   16'd1);
        chk("r81_frame_err", {15'd0, frame_err}, 16'd0);

        // Even parity on 0x07: parity bit 0 is wrong, 1 is right
        pulse_clear();
        send_frame(1'b1, 8'h07, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("par_bad_parity_err", {15'd0, parity_err_p}, 16'd1);
        chk("par_bad_rx_flag",    {15'd0, rx_flag_p},    16'd1);
        chk("par_bad_frame_err",  {15'd0, frame_err_p},  16'd0);
        chk("par_bad_word",       {8'd0, sr_p},          16'h0007);
        chk("nopar_parity_err",   {15'd0, parity_err},   16'd0);
        pulse_clear();
        chk("par_clr",            {15'd0, parity_err_p}, 16'd0);
        send_frame(1'b1, 8'h07, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("par_ok_parity_err",  {15'd0, parity_err_p}, 16'd0);
        chk("par_ok_rx_flag",     {15'd0, rx_flag_p},    16'd1);
        chk("par_ok_word",        {8'd0, sr_p},          16'h0007);

        repeat (4) @(negedge clk);
        chk("bitq_drained",  16'(bitq.size()),  16'd0);
        chk("wordq_drained", 16'(wordq.size()), 16'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
